load_unit: RTL and testbench

//  Multi-cycle data-memory read requester. It produces the data_mem_out value

---
 rtl/load_unit.sv | 145 ++++++++++++++
 tb/tb_load_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// Multi-cycle data-memory load requester: issues a word-aligned read, waits on
// mem_ready with a timeout, then extracts and extends the selected byte/half/word.
module load_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] data_mem_out,
  output logic        load_valid,
  output logic        load_err,
  output logic        busy
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [2:0]        f3_q, f3_n;
  logic [1:0]        off_q, off_n;
  logic              mem_req_n, load_valid_n, load_err_n, busy_n;
  logic [31:0]       mem_addr_n, data_n;

  logic              bad_access_c;
  logic [31:0]       extract_c;
  logic [7:0]        byte_c;
  logic [15:0]       half_c;

  // Illegal funct3 or misaligned half/word access is rejected in IDLE.
  always_comb begin
    bad_access_c = 1'b0;
    case (funct3)
      3'd0, 3'd4: bad_access_c = 1'b0;
      3'd1, 3'd5: bad_access_c = addr[0];
      3'd2:       bad_access_c = (addr[1:0] != 2'b00);
      default:    bad_access_c = 1'b1;
    endcase
  end

  // Lane select and extension using the offset latched at request time.
  always_comb begin
    byte_c    = 8'(mem_rdata >> {off_q, 3'b000});
    half_c    = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    extract_c = mem_rdata;
    case (f3_q)
      3'd0:    extract_c = {{24{byte_c[7]}}, byte_c};
      3'd1:    extract_c = {{16{half_c[15]}}, half_c};
      3'd4:    extract_c = {24'd0, byte_c};
      3'd5:    extract_c = {16'd0, half_c};
      default: extract_c = mem_rdata;
    endcase
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    f3_n         = f3_q;
    off_n        = off_q;
    mem_req_n    = mem_req;
    mem_addr_n   = mem_addr;
    data_n       = data_mem_out;
    busy_n       = busy;
    load_valid_n = 1'b0;
    load_err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (load_en) begin
          if (bad_access_c) begin
            load_err_n = 1'b1;
          end else begin
            state_n    = REQ;
            f3_n       = funct3;
            off_n      = addr[1:0];
            mem_addr_n = {addr[31:2], 2'b00};
            mem_req_n  = 1'b1;
            busy_n     = 1'b1;
            cnt_n      = '0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_n      = DONE;
          data_n       = extract_c;
          mem_req_n    = 1'b0;
          load_valid_n = 1'b1;
          cnt_n        = '0;
        end else if (cnt == CNT_LAST) begin
          state_n    = IDLE;
          mem_req_n  = 1'b0;
          load_err_n = 1'b1;
          busy_n     = 1'b0;
          cnt_n      = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n   = IDLE;
        mem_req_n = 1'b0;
        busy_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      f3_q         <= '0;
      off_q        <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= '0;
      data_mem_out <= '0;
      load_valid   <= 1'b0;
      load_err     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      f3_q         <= f3_n;
      off_q        <= off_n;
      mem_req      <= mem_req_n;
      mem_addr     <= mem_addr_n;
      data_mem_out <= data_n;
      load_valid   <= load_valid_n;
      load_err     <= load_err_n;
      busy         <= busy_n;
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: expected completions are queued at issue time
// and compared whenever load_valid or load_err pulses.
module tb_load_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_en;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] data_mem_out;
  logic        load_valid;
  logic        load_err;
  logic        busy;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_last;
  int          errs;
  int          checks;

  load_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .funct3(funct3), .addr(addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .data_mem_out(data_mem_out),
    .load_valid(load_valid), .load_err(load_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference extraction, written lane by lane.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (o)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = (o >= 2'd2) ? w[31:16] : w[15:0];
    case (f3)
      3'd0: ref_load = b[7] ? {24'hFFFFFF, b} : {24'h0, b};
      3'd1: ref_load = h[15] ? {16'hFFFF, h} : {16'h0, h};
      3'd4: ref_load = {24'h0, b};
      3'd5: ref_load = {16'h0, h};
      default: ref_load = w;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a);
    @(posedge clk); #1;
    load_en = 1'b1; funct3 = f3; addr = a;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic good_load(input logic [2:0] f3, input logic [31:0] a, input int dly,
                           input logic [31:0] rd, input logic [31:0] exp_d);
    exp_q.push_back({1'b0, exp_d});
    model_last = exp_d;
    issue(f3, a);
    check("req_high", 32'(mem_req), 32'd1);
    check("mem_addr", mem_addr, {a[31:2], 2'b00});
    check("busy_req", 32'(busy), 32'd1);
    repeat (dly) begin @(posedge clk); #1; end
    mem_ready = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ready = 1'b0; mem_rdata = $urandom;
    check("valid_latency", 32'(load_valid), 32'd1);
    check("req_drop", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("valid_pulse", 32'(load_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic bad_load(input logic [2:0] f3, input logic [31:0] a);
    exp_q.push_back({1'b1, model_last});
    issue(f3, a);
    check("err_pulse", 32'(load_err), 32'd1);
    check("err_noreq", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check("err_once", 32'(load_err), 32'd0);
    check("err_noreq2", 32'(mem_req), 32'd0);
  endtask

  initial begin
    int          req_cycles;
    logic [31:0] rd;
    logic [1:0]  o;
    logic [2:0]  f3;
    logic [2:0]  legal [5];
    legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2; legal[3] = 3'd4; legal[4] = 3'd5;
    errs = 0; checks = 0; model_last = '0;
    rst = 1'b1; load_en = 1'b0; funct3 = '0; addr = '0;
    mem_ready = 1'b0; mem_rdata = '0;

    // Completion monitor: every pulse must match the oldest queued expectation.
    fork
      forever begin
        @(negedge clk);
        if (!rst && (load_valid || load_err)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pulse", {30'd0, load_err, load_valid}, 32'd0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("kind_err", 32'(load_err), 32'(e.err));
            check("kind_valid", 32'(load_valid), 32'(!e.err));
            check("data_out", data_mem_out, e.data);
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_data", data_mem_out, 32'd0);
    check("rst_flags", {29'd0, load_valid, load_err, busy}, 32'd0);
    rst = 1'b0;

    good_load(3'd2, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF);
    good_load(3'd0, 32'h103, 0, 32'h80112233, 32'hFFFFFF80);
    good_load(3'd4, 32'h103, 1, 32'h80112233, 32'h00000080);
    good_load(3'd1, 32'h202, 2, 32'h9ABC1234, 32'hFFFF9ABC);
    good_load(3'd5, 32'h202, 0, 32'h9ABC1234, 32'h00009ABC);

    bad_load(3'd2, 32'h102);
    bad_load(3'd1, 32'h101);
    bad_load(3'd5, 32'h203);
    bad_load(3'd3, 32'h100);
    bad_load(3'd7, 32'h100);

    for (int i = 0; i < 10; i++) begin
      f3 = legal[$urandom_range(0, 4)];
      o  = 2'($urandom_range(0, 3));
      if (f3 == 3'd2) o = 2'd0;
      else if (f3 == 3'd1 || f3 == 3'd5) o[0] = 1'b0;
      rd = $urandom;
      good_load(f3, {20'h00040, 10'($urandom), o}, $urandom_range(0, 3), rd,
                ref_load(f3, o, rd));
    end

    // Timeout: no ready for the whole window.
    exp_q.push_back({1'b1, model_last});
    issue(3'd2, 32'h300);
    req_cycles = 0;
    while (mem_req && req_cycles < 40) begin
      req_cycles++;
      @(posedge clk); #1;
    end
    check("timeout_cycles", 32'(req_cycles), 32'd16);
    check("timeout_err", 32'(load_err), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    good_load(3'd2, 32'h304, 0, 32'h12345678, 32'h12345678);

    // load_en during REQ is ignored: address holds and no second request follows.
    exp_q.push_back({1'b0, 32'hCAFEF00D});
    model_last = 32'hCAFEF00D;
    issue(3'd2, 32'h400);
    load_en = 1'b1; funct3 = 3'd2; addr = 32'h500;
    @(posedge clk); #1;
    load_en = 1'b0;
    check("ignore_addr", mem_addr, 32'h400);
    check("ignore_req", 32'(mem_req), 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    check("ignore_valid", 32'(load_valid), 32'd1);
    req_cycles = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_req) req_cycles++;
    end
    check("ignore_no_second_req", 32'(req_cycles), 32'd0);

    // Reset in the middle of a request aborts it silently.
    issue(3'd2, 32'h600);
    check("abort_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_req", 32'(mem_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_data", data_mem_out, 32'd0);
    rst = 1'b0;
    model_last = '0;
    mem_ready = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    mem_ready = 1'b0;
    check("abort_quiet", {30'd0, load_valid, mem_req}, 32'd0);
    bad_load(3'd2, 32'h001);
    good_load(3'd4, 32'h701, 1, 32'h0000A500, 32'h000000A5);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
